// File: rtl/pic_gray_packer_if.sv
// Valid/ready stream with frame framing. It carries the pixel input (W=DW0) and the packed output word (W=DN*DW).
interface pic_gray_packer_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         first;
  logic         last;
  logic         valid;
  logic         ready;

  modport master (output data, output first, output last, output valid, input ready);
  modport slave  (input data, input first, input last, input valid, output ready);
endinterface

// File: rtl/pic_gray_packer.sv
// RGB565 -> 8-bit grey (or raw low byte) packer. DN pixels form one word, visible 1 cycle after the completing pixel.
// 1-deep output register: input is stalled whenever a word is held and m.ready is low.
module pic_gray_packer #(
  parameter int             DW0 = 16,
  parameter int             DW  = 8,
  parameter int             DN  = 7,
  parameter logic [DW-1:0]  PAD = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    gray_en,
  pic_gray_packer_if.slave        pic,
  pic_gray_packer_if.master       m,
  output logic                    sync_err,
  output logic                    frame_done
);

  localparam int                CW       = (DN > 1) ? $clog2(DN) : 1;
  localparam logic [DN*DW-1:0]  PAD_WORD = {DN{PAD}};

  function automatic logic [7:0] to_gray(input logic [15:0] px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5],  px[10:9]};
    b8  = {px[4:0],   px[4:2]};
    // Weights add up to 256, so the sum never exceeds 255*256 and fits in 16 bits
    sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    return sum[15:8];
  endfunction

  logic [CW-1:0]     cnt;
  logic              pend_first;
  logic [DN*DW-1:0]  pack_q;
  logic              valid_q;
  logic [DN*DW-1:0]  data_q;
  logic              first_q;
  logic              last_q;

  logic              accept;
  logic              resync;
  logic              complete;
  logic [CW-1:0]     idx;
  logic [7:0]        lane8;
  logic [DW-1:0]     pix_lane;
  logic [DN*DW-1:0]  word_nxt;

  assign pic.ready = !valid_q | m.ready;
  assign m.valid   = valid_q;
  assign m.data    = data_q;
  assign m.first   = first_q;
  assign m.last    = last_q;

  always_comb begin
    accept   = pic.valid & pic.ready;
    resync   = pic.first & (cnt != '0);
    lane8    = gray_en ? to_gray(pic.data[15:0]) : pic.data[7:0];
    pix_lane = DW'(lane8);
    // A resync restarts from an all-PAD buffer so no stale lanes survive
    idx      = resync ? '0 : cnt;
    word_nxt = resync ? PAD_WORD : pack_q;
    for (int k = 0; k < DN; k++) begin
      if (idx == CW'(k)) begin
        word_nxt[k*DW +: DW] = pix_lane;
      end
    end
    complete = accept & ((idx == CW'(DN - 1)) | pic.last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      pend_first <= 1'b0;
      pack_q     <= PAD_WORD;
      valid_q    <= 1'b0;
      data_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sync_err   <= accept & resync;
      frame_done <= valid_q & m.ready & last_q;
      if (valid_q & m.ready) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          // Lanes above idx are already PAD: the buffer is refilled with PAD after every word
          data_q     <= word_nxt;
          first_q    <= pend_first | pic.first;
          last_q     <= pic.last;
          valid_q    <= 1'b1;
          cnt        <= '0;
          pack_q     <= PAD_WORD;
          pend_first <= 1'b0;
        end else begin
          pack_q     <= word_nxt;
          cnt        <= idx + CW'(1);
          pend_first <= pend_first | pic.first;
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_gray_packer.sv
// Directed test of pic_gray_packer with DN=7 and PAD=8'hEE.
module tb_pic_gray_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gray_en = 1'b1;
  logic sync_err;
  logic frame_done;

  int total = 0;
  int bad = 0;
  int words = 0;

  always #5 clk = ~clk;

  pic_gray_packer_if #(.W(16)) pic ();
  pic_gray_packer_if #(.W(56)) m ();

  pic_gray_packer #(.DW0(16), .DW(8), .DN(7), .PAD(8'hEE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_en    (gray_en),
    .pic        (pic),
    .m          (m),
    .sync_err   (sync_err),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (rst_n && m.valid && m.ready) words++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic f, input logic l);
    int guard;
    guard = 0;
    pic.data  = d;
    pic.first = f;
    pic.last  = l;
    pic.valid = 1'b1;
    while (!pic.ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!pic.ready) chk("send_timeout", {63'd0, pic.ready}, 64'd1);
    tick();
    pic.valid = 1'b0;
    pic.first = 1'b0;
    pic.last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int stall_bad;
    pic.data  = '0;
    pic.first = 1'b0;
    pic.last  = 1'b0;
    pic.valid = 1'b0;
    m.ready   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_valid", m.valid, 0);
    chk("rst_data", m.data, 0);
    chk("rst_first", m.first, 0);
    chk("rst_last", m.last, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pic_ready", pic.ready, 1);

    // 1: seven white pixels
    gray_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(16'hFFFF, i == 0, 1'b0);
      if (i == 5) chk("t1_no_early_valid", m.valid, 0);
    end
    chk("t1_valid", m.valid, 1);
    chk("t1_data", m.data, 56'hFFFFFFFFFFFFFF);
    chk("t1_first", m.first, 1);
    chk("t1_last", m.last, 0);
    tick();
    chk("t1_drop_valid", m.valid, 0);
    chk("t1_no_frame_done", frame_done, 0);

    // 2: primaries, short word, last without first
    send(16'hF800, 1'b0, 1'b0);
    send(16'h07E0, 1'b0, 1'b0);
    send(16'h001F, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b1);
    chk("t2_data", m.data, 56'hEEEEEE001C954C);
    chk("t2_first", m.first, 0);
    chk("t2_last", m.last, 1);
    chk("t2_fd_before", frame_done, 0);
    tick();
    chk("t2_fd_pulse", frame_done, 1);
    tick();
    chk("t2_fd_end", frame_done, 0);

    // 3: raw 9-pixel frame
    gray_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(16'h0101 + 16'(i), i == 0, i == 8);
      if (i == 6) begin
        chk("t3_w1_data", m.data, 56'h07060504030201);
        chk("t3_w1_first", m.first, 1);
        chk("t3_w1_last", m.last, 0);
      end
    end
    chk("t3_w2_data", m.data, 56'hEEEEEEEEEE0908);
    chk("t3_w2_first", m.first, 0);
    chk("t3_w2_last", m.last, 1);
    tick();

    // 4: backpressure with a pixel offered
    m.ready = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h5511 + 16'(i), i == 0, 1'b0);
    chk("t4_held_valid", m.valid, 1);
    chk("t4_held_data", m.data, 56'h17161514131211);
    pic.data  = 16'h6621;
    pic.first = 1'b1;
    pic.valid = 1'b1;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pic.ready !== 1'b0 || m.data !== 56'h17161514131211 || m.valid !== 1'b1) stall_bad++;
    end
    chk("t4_stall_cycles", stall_bad, 0);
    w0 = words;
    m.ready = 1'b1;
    #1;
    chk("t4_ready_same_cycle", pic.ready, 1);
    tick();
    pic.valid = 1'b0;
    pic.first = 1'b0;
    chk("t4_drop_valid", m.valid, 0);
    chk("t4_one_word", words - w0, 1);
    for (int i = 1; i < 7; i++) send(16'h6621 + 16'(i), 1'b0, 1'b0);
    chk("t4_next_data", m.data, 56'h27262524232221);
    chk("t4_next_first", m.first, 1);
    tick();

    // 5: resync at cnt=3
    send(16'h0031, 1'b1, 1'b0);
    send(16'h0032, 1'b0, 1'b0);
    send(16'h0033, 1'b0, 1'b0);
    w0 = words;
    send(16'h0041, 1'b1, 1'b0);
    chk("t5_sync_err", sync_err, 1);
    chk("t5_no_word", m.valid, 0);
    tick();
    chk("t5_sync_err_end", sync_err, 0);
    for (int i = 1; i < 7; i++) send(16'h0041 + 16'(i), 1'b0, 1'b0);
    chk("t5_data", m.data, 56'h47464544434241);
    chk("t5_first", m.first, 1);
    chk("t5_sync_err_quiet", sync_err, 0);
    tick();
    chk("t5_one_word", words - w0, 1);

    // 6: reset with a held word, then reset mid-word
    m.ready = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h0051 + 16'(i), i == 0, 1'b0);
    chk("t6_held_valid", m.valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_valid", m.valid, 0);
    chk("t6_rst_data", m.data, 0);
    chk("t6_rst_first", m.first, 0);
    chk("t6_rst_last", m.last, 0);
    chk("t6_rst_flags", {sync_err, frame_done}, 0);
    for (int i = 0; i < 4; i++) send(16'h0061 + 16'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m.ready = 1'b1;
    w0 = words;
    for (int i = 0; i < 7; i++) begin
      send(16'h0071 + 16'(i), 1'b0, 1'b0);
      if (i == 2) chk("t6_no_early_word", m.valid, 0);
    end
    chk("t6_clean_data", m.data, 56'h77767574737271);
    chk("t6_clean_first", m.first, 0);
    tick();
    chk("t6_one_word", words - w0, 1);

    // 7: first and last on one pixel
    send(16'h3381, 1'b1, 1'b1);
    chk("t7_data", m.data, 56'hEEEEEEEEEEEE81);
    chk("t7_first_last", {m.first, m.last}, 2'b11);
    tick();
    chk("t7_fd", frame_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
